alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_pkg.sv | 20 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 24 ++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and defaults for the two-requester ALU share arbiter.
package alu_arb_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OPW  = 4;
  localparam int NUM_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [ALU_OPW-1:0]  op;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Combinational 2-way one-hot grant. ALU_ARB_RR_EN selects round-robin
// on ptr (ptr names the favoured requester); otherwise requester 0 always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      // Win when favoured, or when the other side is not asking.
      assign gnt[gi] = valid[gi] & ((ptr == 1'(gi)) | ~valid[1-gi]);
    end
  endgenerate
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign gnt[0]     = valid[0];
  assign gnt[1]     = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between the core (req 0) and debug port (req 1).
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int OPW  = ALU_OPW
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b_i,
  input  logic [NUM_REQ-1:0][OPW-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [XLEN-1:0]               rsp_f_o,
  output logic                          rsp_c_o,
  output logic                          rsp_ov_o,
  output logic                          rsp_zero_o,
  output logic [XLEN-1:0]               alu_a_o,
  output logic [XLEN-1:0]               alu_b_o,
  output logic [OPW-1:0]                alu_op_o,
  input  logic [XLEN-1:0]               alu_f_i,
  input  logic                          alu_c_i,
  input  logic                          alu_ov_i,
  input  logic                          alu_zero_i
);

  arb_state_t      state_reg, state_next;
  logic            owner_reg, owner_next;
  alu_req_t        req_reg, req_next;
  logic [XLEN-1:0] rsp_f_reg;
  logic            rsp_c_reg, rsp_ov_reg, rsp_zero_reg;
  logic            arb_ptr;
  logic [1:0]      gnt;
  logic            accept;
  logic            rsp_done;

  assign accept   = (state_reg == IDLE) && (gnt != 2'b00);
  assign rsp_done = (state_reg == RESP) && rsp_ready_i[owner_reg];

`ifdef ALU_ARB_RR_EN
  logic ptr_reg, ptr_next;

  // After a completed response the other requester is favoured next.
  always_comb begin
    ptr_next = ptr_reg;
    if (rsp_done) ptr_next = ~owner_reg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_reg <= 1'b0;
    else         ptr_reg <= ptr_next;
  end

  assign arb_ptr = ptr_reg;
`else
  assign arb_ptr = 1'b0;
`endif

  rr_arb2 u_arb (
    .valid (req_valid_i),
    .ptr   (arb_ptr),
    .gnt   (gnt)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)   state_next = EXEC;
      EXEC:                  state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    owner_next = owner_reg;
    req_next   = req_reg;
    if (accept) begin
      owner_next  = gnt[1];
      req_next.a  = req_a_i[gnt[1]];
      req_next.b  = req_b_i[gnt[1]];
      req_next.op = req_op_i[gnt[1]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      req_reg      <= '0;
      rsp_f_reg    <= '0;
      rsp_c_reg    <= 1'b0;
      rsp_ov_reg   <= 1'b0;
      rsp_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      req_reg   <= req_next;
      if (state_reg == EXEC) begin
        rsp_f_reg    <= alu_f_i;
        rsp_c_reg    <= alu_c_i;
        rsp_ov_reg   <= alu_ov_i;
        rsp_zero_reg <= alu_zero_i;
      end
    end
  end

  // ALU inputs are only non-zero during the single execute cycle.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_op_o    = '0;
    case (state_reg)
      IDLE: req_ready_o = gnt;
      EXEC: begin
        alu_a_o  = req_reg.a;
        alu_b_o  = req_reg.b;
        alu_op_o = req_reg.op;
      end
      RESP:    rsp_valid_o[owner_reg] = 1'b1;
      default: ;
    endcase
  end

  assign rsp_f_o    = rsp_f_reg;
  assign rsp_c_o    = rsp_c_reg;
  assign rsp_ov_o   = rsp_ov_reg;
  assign rsp_zero_o = rsp_zero_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU closing the loop.
module tb_alu_share_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][XLEN-1:0]  req_a, req_b;
  logic [1:0][OPW-1:0]   req_op;
  logic [XLEN-1:0]       rsp_f, alu_a, alu_b, alu_f;
  logic                  rsp_c, rsp_ov, rsp_zero, alu_c, alu_ov, alu_zero;
  logic [OPW-1:0]        alu_op;

  int pass_cnt  = 0;
  int total_cnt = 0;
  // {owner, c, ov, zero, f}
  logic [35:0] exp_q[$];

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_f_o     (rsp_f),
    .rsp_c_o     (rsp_c),
    .rsp_ov_o    (rsp_ov),
    .rsp_zero_o  (rsp_zero),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_f_i     (alu_f),
    .alu_c_i     (alu_c),
    .alu_ov_i    (alu_ov),
    .alu_zero_i  (alu_zero)
  );

  // Returns {c, ov, zero, f}. Sub reports borrow in c.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [32:0] s;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'b0000: begin
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0001: begin
        s  = {1'b0, a} - {1'b0, b};
        ov = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b1111: s = {1'b0, a + {30'd0, b[1:0]}};
      default: s = {1'b0, a & b};
    endcase
    return {s[32], ov, (s[31:0] == 32'd0), s[31:0]};
  endfunction

  always_comb {alu_c, alu_ov, alu_zero, alu_f} = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: push on request handshake, pop/compare on response handshake.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (req_valid[k] && req_ready[k])
          exp_q.push_back({1'(k), alu_fn(req_a[k], req_b[k], req_op[k])});
        if (rsp_valid[k] && rsp_ready[k]) begin
          chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("rsp owner=%0d f=0x%08h c=%0b ov=%0b z=%0b", k, rsp_f, rsp_c, rsp_ov, rsp_zero);
            chk("rsp_owner", 64'(k), 64'(e[35]));
            chk("rsp_f", 64'(rsp_f), 64'(e[31:0]));
            chk("rsp_flags", 64'({rsp_c, rsp_ov, rsp_zero}), 64'(e[34:32]));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(output int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((req_valid & req_ready) == 2'b00) && (n < 20));
    chk("hs_seen", 64'((req_valid & req_ready) != 2'b00), 64'd1);
    id = req_ready[1] ? 1 : 0;
    $display("req handshake id=%0d a=0x%08h b=0x%08h op=%h", id, req_a[id], req_b[id], req_op[id]);
    step();
  endtask

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    int got;
    req_a[id]     = a;
    req_b[id]     = b;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    wait_hs(got);
    chk("grant_id", 64'(got), 64'(id));
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[id] && (n < 20));
    chk("rsp_valid_owner", 64'(rsp_valid), 64'(2'b01 << id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int got;
`ifdef ALU_ARB_RR_EN
  int exp_ord[3] = '{0, 1, 0};
`else
  int exp_ord[3] = '{0, 0, 0};
`endif

  initial begin
    req_valid = '0;
    rsp_ready = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    // Reset state
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_f", 64'(rsp_f), 64'd0);
    chk("rst_flags", 64'({rsp_c, rsp_ov, rsp_zero}), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_op}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single add: exact 2-cycle latency
    send(0, 32'd5, 32'd3, 4'b0000);
    @(negedge clk);
    chk("exec_alu_a", 64'(alu_a), 64'd5);
    chk("exec_alu_b", 64'(alu_b), 64'd3);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("add_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("add_f", 64'(rsp_f), 64'd8);
    chk("add_c", 64'(rsp_c), 64'd0);
    step();
    @(negedge clk);
    chk("add_idle_valid", 64'(rsp_valid), 64'd0);
    step();

    // Count op: opcode and full B passed through unmodified
    send(0, 32'h10, 32'hFFFF_FFFE, 4'b1111);
    @(negedge clk);
    chk("cnt_alu_b", 64'(alu_b), 64'hFFFF_FFFE);
    chk("cnt_alu_op", 64'(alu_op), 64'hF);
    wait_rsp(0);
    chk("cnt_f", 64'(rsp_f), 64'h12);
    step();

    // Subtract with borrow from requester 1
    send(1, 32'd3, 32'd5, 4'b0001);
    wait_rsp(1);
    chk("sub_f", 64'(rsp_f), 64'hFFFF_FFFE);
    step();

    // Contention: 0 first, 1 held off until the first response completes
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = 4'b0000;
    req_a[1] = 32'd2; req_b[1] = 32'd2; req_op[1] = 4'b0000;
    req_valid = 2'b11;
    wait_hs(got);
    chk("cont_first", 64'(got), 64'd0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("cont_ready1_exec", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    chk("cont_ready1_resp", 64'(req_ready[1]), 64'd0);
    chk("cont_f0", 64'(rsp_f), 64'd2);
    step();
    wait_hs(got);
    chk("cont_second", 64'(got), 64'd1);
    req_valid[1] = 1'b0;
    wait_rsp(1);
    chk("cont_f1", 64'(rsp_f), 64'd4);
    step();

    // Backpressure: response held, non-owner ready ignored
    rsp_ready = 2'b00;
    send(0, 32'd7, 32'd9, 4'b0000);
    req_a[1] = 32'h11; req_b[1] = 32'h22; req_op[1] = 4'b0000;
    req_valid[1] = 1'b1;
    wait_rsp(0);
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'b01);
      chk("bp_f", 64'(rsp_f), 64'd16);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_alu_a", 64'(alu_a), 64'd0);
      step();
      if (i == 4) rsp_ready = 2'b10;
      @(negedge clk);
    end
    step();
    rsp_ready = 2'b01;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_release_idle", 64'(rsp_valid), 64'd0);
    chk("bp_next_ready", 64'(req_ready), 64'b10);
    step();
    req_valid[1] = 1'b0;
    rsp_ready = 2'b11;
    wait_rsp(1);
    chk("bp_f1", 64'(rsp_f), 64'h33);
    step();

    // Reset during EXEC discards the operation
    send(0, 32'h100, 32'h200, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 64'd0);
    chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mrst_rsp_f", 64'(rsp_f), 64'd0);
    chk("mrst_flags", 64'({rsp_c, rsp_ov, rsp_zero}), 64'd0);
    chk("mrst_alu", 64'({alu_a, alu_op}), 64'd0);
    chk("mrst_alu_b", 64'(alu_b), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();

    // Both valid for three transactions
    req_a[0] = 32'h40; req_b[0] = 32'd1; req_op[0] = 4'b0000;
    req_a[1] = 32'h80; req_b[1] = 32'd2; req_op[1] = 4'b0000;
    req_valid = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_hs(got);
      chk("both_grant", 64'(got), 64'(exp_ord[t]));
    end
    req_valid = 2'b00;
    wait_rsp(exp_ord[2]);
    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
